// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer and its hold register.
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cntWidth(input int width);
        return $clog2(width);
    endfunction

    localparam int DEFAULT_CNT_W = cntWidth(DEFAULT_WIDTH);

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-word valid/ready handshake feeding the bit serializer.
interface bit_serializer_if
    import ser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );

endinterface

// File: rtl/ser_hold_reg.sv
// One-entry holding register that parks the next word while the shifter is busy.
module ser_hold_reg
    import ser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_wr,
    input  logic             i_rd,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_wr) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_rd) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word hold register so consecutive
// words leave as one continuous bitstream.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    bit_serializer_if.slave        bus,
    output logic                   x_out,
    output logic                   x_valid,
    output logic                   word_done,
    output logic                   busy
);

    localparam int               CNT_W    = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    ser_state_t       r_state;
    ser_state_t       w_stateNext;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shiftNext;
    logic [WIDTH-1:0] w_shifted;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [WIDTH-1:0] w_holdData;
    logic             w_holdFull;
    logic             w_holdWr;
    logic             w_holdRd;
    logic             w_accept;
    logic             w_last;

    assign bus.din_ready = !w_holdFull;
    assign w_accept      = bus.din_valid && !w_holdFull;
    assign w_last        = (r_state == SHIFT) && (r_cnt == LAST_CNT);
    assign w_shifted     = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                     : {1'b0, r_shift[WIDTH-1:1]};

    ser_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_wr    (w_holdWr),
        .i_rd    (w_holdRd),
        .i_data  (bus.din),
        .o_data  (w_holdData),
        .o_full  (w_holdFull)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_shift <= w_shiftNext;
            r_cnt   <= w_cntNext;
        end
    end

    // On the last bit the next word (held or arriving) is loaded at once, so no idle gap appears.
    always_comb begin
        w_stateNext = r_state;
        w_shiftNext = r_shift;
        w_cntNext   = r_cnt;
        w_holdWr    = 1'b0;
        w_holdRd    = 1'b0;
        if (flush) begin
            w_stateNext = IDLE;
            w_shiftNext = '0;
            w_cntNext   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_stateNext = SHIFT;
                        w_shiftNext = bus.din;
                        w_cntNext   = '0;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        w_cntNext = '0;
                        if (w_holdFull) begin
                            w_shiftNext = w_holdData;
                            w_holdRd    = 1'b1;
                        end else if (w_accept) begin
                            w_shiftNext = bus.din;
                        end else begin
                            w_stateNext = IDLE;
                            w_shiftNext = '0;
                        end
                    end else begin
                        w_shiftNext = w_shifted;
                        w_cntNext   = r_cnt + CNT_W'(1);
                        w_holdWr    = w_accept;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    assign x_valid   = (r_state == SHIFT);
    assign x_out     = x_valid && (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
    assign word_done = w_last;
    assign busy      = (r_state == SHIFT) || w_holdFull;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance
// share stimulus and are checked every cycle against a bit-queue model.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [W-1:0] din;
    logic         dinValid;

    logic xOutM, xValidM, doneM, busyM;
    logic xOutL, xValidL, doneL, busyL;

    int assertCount = 0;
    int failCount   = 0;

    bit qM[$];
    bit qL[$];

    bit monEn = 0;
    int cycleIdx, statValid, statDone, statReadyLow, firstV, lastV;

    bit_serializer_if #(.WIDTH(W)) busMsb ();
    bit_serializer_if #(.WIDTH(W)) busLsb ();

    assign busMsb.din       = din;
    assign busMsb.din_valid = dinValid;
    assign busLsb.din       = din;
    assign busLsb.din_valid = dinValid;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (busMsb.slave),
        .x_out     (xOutM),
        .x_valid   (xValidM),
        .word_done (doneM),
        .busy      (busyM)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (busLsb.slave),
        .x_out     (xOutL),
        .x_valid   (xValidL),
        .word_done (doneL),
        .busy      (busyL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted word becomes W queued bits; one bit leaves per clock.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            qM.delete();
            qL.delete();
        end else if (flush) begin
            qM.delete();
            qL.delete();
        end else begin
            automatic bit wasReady = (qM.size() <= W);
            if (qM.size() > 0) begin
                void'(qM.pop_front());
                void'(qL.pop_front());
            end
            if (dinValid && wasReady) begin
                for (int i = 0; i < W; i++) begin
                    qM.push_back(din[W-1-i]);
                    qL.push_back(din[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        automatic int  n      = qM.size();
        automatic bit  expV   = (n > 0);
        automatic bit  expOM  = (n > 0) ? qM[0] : 1'b0;
        automatic bit  expOL  = (n > 0) ? qL[0] : 1'b0;
        automatic bit  expD   = (n > 0) && (((n - 1) % W) == 0);
        automatic bit  expRdy = (n <= W);
        checkOutput("msbValid", 32'(xValidM), 32'(expV));
        checkOutput("msbOut",   32'(xOutM),   32'(expOM));
        checkOutput("msbDone",  32'(doneM),   32'(expD));
        checkOutput("msbBusy",  32'(busyM),   32'(expV));
        checkOutput("msbReady", 32'(busMsb.din_ready), 32'(expRdy));
        checkOutput("lsbValid", 32'(xValidL), 32'(expV));
        checkOutput("lsbOut",   32'(xOutL),   32'(expOL));
        checkOutput("lsbDone",  32'(doneL),   32'(expD));
        checkOutput("lsbReady", 32'(busLsb.din_ready), 32'(expRdy));
    end

    always @(negedge clk) begin
        if (monEn) begin
            cycleIdx++;
            if (xValidM) begin
                statValid++;
                if (firstV < 0) firstV = cycleIdx;
                lastV = cycleIdx;
            end
            if (doneM) statDone++;
            if (!busMsb.din_ready) statReadyLow++;
        end
    end

    task automatic clearStats();
        cycleIdx = 0; statValid = 0; statDone = 0; statReadyLow = 0;
        firstV = -1; lastV = -1;
        monEn = 1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] data, input logic valid, input logic fl);
        din = data;
        dinValid = valid;
        flush = fl;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the word on the bus until the edge that takes it; leaves din_valid high.
    task automatic sendWord(input logic [W-1:0] data);
        bit accepted = 0;
        applyStimulus(data, 1'b1, 1'b0);
        for (int k = 0; k < 50 && !accepted; k++) begin
            accepted = (busMsb.din_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        checkOutput("acceptWithinBound", 32'(accepted), 32'd1);
    endtask

    task automatic captureBits(output logic [W-1:0] capM, output logic [W-1:0] capL,
                               output int doneCount, output logic doneLast);
        doneCount = 0;
        doneLast = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            capM = {capM[W-2:0], xOutM};
            capL = {capL[W-2:0], xOutL};
            if (doneM) doneCount++;
            if (i == W - 1) doneLast = doneM;
        end
    endtask

    initial begin
        logic [W-1:0] capM, capL;
        int           doneCount;
        logic         doneLast;

        applyStimulus('0, 1'b0, 1'b0);
        rst = 1'b1;
        #1 rst = 1'b0;
        waitCycles(2);
        checkOutput("resetValid", 32'(xValidM), 32'd0);
        checkOutput("resetOut",   32'(xOutM),   32'd0);
        checkOutput("resetDone",  32'(doneM),   32'd0);
        checkOutput("resetBusy",  32'(busyM),   32'd0);
        checkOutput("resetReady", 32'(busMsb.din_ready), 32'd1);
        rst = 1'b1;
        waitCycles(2);

        $display("[TB] single word 0xB0");
        sendWord(8'hB0);
        applyStimulus('0, 1'b0, 1'b0);
        captureBits(capM, capL, doneCount, doneLast);
        checkOutput("singleMsbBits", 32'(capM), 32'hB0);
        checkOutput("singleLsbBits", 32'(capL), 32'h0D);
        checkOutput("singleDoneCount", 32'(doneCount), 32'd1);
        checkOutput("singleDoneOn8th", 32'(doneLast), 32'd1);
        @(negedge clk);
        checkOutput("singleIdleAfter", 32'(xValidM), 32'd0);
        waitCycles(3);

        $display("[TB] back-to-back 0xB0, 0xFF");
        clearStats();
        sendWord(8'hB0);
        sendWord(8'hFF);
        applyStimulus('0, 1'b0, 1'b0);
        waitCycles(24);
        checkOutput("b2bValidCycles", 32'(statValid), 32'd16);
        checkOutput("b2bNoGap", 32'(lastV - firstV + 1), 32'd16);
        checkOutput("b2bDonePulses", 32'(statDone), 32'd2);
        checkOutput("b2bReadyLowCycles", 32'(statReadyLow), 32'd7);

        $display("[TB] bypass on last-bit edge");
        clearStats();
        sendWord(8'hB0);
        applyStimulus('0, 1'b0, 1'b0);
        waitCycles(7);
        checkOutput("bypassInDoneCycle", 32'(doneM), 32'd1);
        sendWord(8'h5A);
        applyStimulus('0, 1'b0, 1'b0);
        waitCycles(16);
        checkOutput("bypassValidCycles", 32'(statValid), 32'd16);
        checkOutput("bypassNoGap", 32'(lastV - firstV + 1), 32'd16);
        checkOutput("bypassDonePulses", 32'(statDone), 32'd2);
        checkOutput("bypassHoldUnused", 32'(statReadyLow), 32'd0);

        $display("[TB] LSB-first 0x0D");
        sendWord(8'h0D);
        applyStimulus('0, 1'b0, 1'b0);
        captureBits(capM, capL, doneCount, doneLast);
        checkOutput("lsbFirstBits", 32'(capL), 32'hB0);
        checkOutput("lsbMsbInstBits", 32'(capM), 32'h0D);
        waitCycles(3);

        $display("[TB] flush mid-word");
        clearStats();
        sendWord(8'hB0);
        sendWord(8'hC3);
        applyStimulus('0, 1'b0, 1'b0);
        waitCycles(2);
        checkOutput("flushHoldFull", 32'(busMsb.din_ready), 32'd0);
        applyStimulus(8'h77, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("flushValid", 32'(xValidM), 32'd0);
        checkOutput("flushBusy",  32'(busyM),   32'd0);
        checkOutput("flushReady", 32'(busMsb.din_ready), 32'd1);
        applyStimulus('0, 1'b0, 1'b0);
        clearStats();
        waitCycles(20);
        checkOutput("flushNoResidue", 32'(statValid), 32'd0);

        $display("[TB] reset mid-word");
        sendWord(8'hB0);
        sendWord(8'hFF);
        applyStimulus('0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midResetValid", 32'(xValidM), 32'd0);
        checkOutput("midResetOut",   32'(xOutM),   32'd0);
        checkOutput("midResetBusy",  32'(busyM),   32'd0);
        checkOutput("midResetReady", 32'(busMsb.din_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        clearStats();
        waitCycles(20);
        checkOutput("postResetSilent", 32'(statValid), 32'd0);

        monEn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete, actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream feeder for the serial sequence-detector stage.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a serial line, together with a valid qualifier.
- A one-entry hold register lets back-to-back words stream with no idle gap, so the downstream detector sees a continuous bitstream across word boundaries.

Parameters:
- WIDTH, 8: bits per parallel word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately while low.
- flush  input  1  synchronous clear: drops the hold register and the word in flight.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block can accept a word this cycle; a transfer occurs when din_valid and din_ready are both high at a rising edge.
- x_out  output  1  serial bit to the downstream detector (its x input).
- x_valid  output  1  x_out carries a real data bit.
- word_done  output  1  high during the cycle the last bit of a word is on x_out.
- busy  output  1  shifter active or hold register occupied.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, shift register 0, bit counter 0, hold register empty. Outputs: x_out=0, x_valid=0, word_done=0, busy=0, din_ready=1.
- din_ready = NOT hold_full. This is combinational from registered state only; it never depends on din_valid.
- States: IDLE, SHIFT.
- IDLE:
  - x_valid=0 and x_out=0.
  - On an accepted word at edge N: load the shifter directly (bypassing the hold register), set cnt=0, go to SHIFT.
  - The first bit appears on x_out in the cycle after edge N (latency 1).
- SHIFT:
  - x_valid=1.
  - x_out = shifter bit WIDTH-1 when MSB_FIRST=1, shifter bit 0 when MSB_FIRST=0.
  - Each edge shifts the register one position toward the output end and increments cnt.
- Last bit: when cnt==WIDTH-1, word_done=1 for that cycle. At the following edge:
  - Hold register full: load hold into the shifter, clear hold_full, cnt=0, stay in SHIFT. No gap between words.
  - Hold empty but a word is accepted at this same edge: bypass-load it into the shifter, stay in SHIFT. No gap.
  - Otherwise: go to IDLE.
- Accept while in SHIFT, not on the last-bit edge: the word goes into the hold register and hold_full=1.
- Because din_ready is low whenever hold is full, a hold load and a hold write can never both be requested at one edge.
- cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1; no wrap beyond the word length.
- busy = (state==SHIFT) OR hold_full.
- flush:
  - Highest priority after rst.
  - At the edge where it is sampled: state IDLE, hold_full=0, cnt=0. Any din transfer in that same cycle is discarded.
  - din_ready reads 1 in the cycle after the flush.
- Reset asserted mid-word: the output stream stops immediately with x_valid=0. No partial word resumes after reset is released.
- x_out stays 0 whenever x_valid=0, so the downstream detector never sees stale data bits during idle.

Decomposition:
- Shared package ser_pkg:
  - State enumeration IDLE/SHIFT.
  - Default WIDTH constant.
  - Counter-width constant derived with $clog2(WIDTH).
- Sub-module ser_hold_reg: one-entry register with write enable, read/clear enable, data and full flag. The top level keeps the FSM, shifter and counter.

Test Plan (WIDTH=8):
- Reset: rst low mid-stream -> x_valid=0, x_out=0, din_ready=1, busy=0 in the same cycle; after release, no bits until a new word is accepted.
- Single word, MSB_FIRST=1: din=8'hB0 accepted in IDLE -> from the next cycle x_out = 1,0,1,1,0,0,0,0 with x_valid=1 for exactly 8 cycles; word_done on the 8th; then IDLE.
- Back-to-back words: 8'hB0 then 8'hFF offered with din_valid held high -> 16 consecutive x_valid cycles with no gap. din_ready drops after the second accept and rises on the hold-to-shifter transfer. word_done pulses at bit 8 and bit 16.
- Bypass on the last-bit edge: second word offered exactly in the word_done cycle with hold empty -> accepted, no gap, hold_full never set.
- LSB-first: MSB_FIRST=0, din=8'h0D -> x_out = 1,0,1,1,0,0,0,0.
- Flush: flush at bit 3 of 8'hB0 with a word in hold and din_valid high -> next cycle x_valid=0, busy=0, din_ready=1. The word offered in the flush cycle is not transmitted.
